// File: rtl/warmboot_sequencer_pkg.sv
// Shared definitions for the warmboot sequencer: FSM state encoding,
// image-select constants and a small width helper for the counters.
package warmboot_sequencer_pkg;

  // Sequencer states. WAIT: auto-boot timeout running. HOST: USB host present.
  // DRAIN: waiting for the flash bus to go quiet. ARM: S lines driven and settling.
  // FIRE: BOOT pulse asserted. DONE: terminal until reset.
  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_HOST  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ARM   = 3'd3,
    ST_FIRE  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // {S1,S0} image selects for SB_WARMBOOT.
  localparam logic [1:0] IMG_BOOTLOADER = 2'b00;
  localparam logic [1:0] IMG_USER       = 2'b01;

  // Number of cycles the S lines are held stable before BOOT rises.
  localparam int ARM_CYCLES = 2;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warmboot_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset (count -> 0)
//   clr_i   : synchronous clear, dominates enable
//   en_i    : count enable
//   q_o     : current count; stops at MAX and never wraps
//   tc_o    : terminal count, high while q_o == MAX
module warmboot_sequencer_sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o  = cnt_q;
  assign tc_o = (cnt_q == MAX);

endmodule

// File: rtl/warmboot_sequencer.sv
// Decides when, and to which image, the iCE40 SB_WARMBOOT primitive reboots
// the part. Boots DEFAULT_IMAGE after TIMEOUT_CYCLES with no USB activity, or
// a host-selected image on boot_req. Flash traffic is quiesced first, then
// {S1,S0} is presented for ARM_CYCLES before BOOT is pulsed for BOOT_HOLD cycles.
//
// Interface protocol: usb_active and boot_req are single-cycle pulses acted on
// only in WAIT/HOST; boot_image is sampled only together with boot_req.
// spi_inhibit is a level: while high the SPI master must not start a new
// transaction, but one already in flight (spi_cs low) is allowed to finish.
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high
//   usb_active      in   pulse per valid USB token/SOF
//   boot_req        in   pulse: host requested reboot
//   boot_image[1:0] in   {S1,S0} image requested with boot_req
//   spi_cs          in   flash chip select, active low
//   spi_inhibit     out  block new SPI transactions
//   wb_s[1:0]       out  SB_WARMBOOT {S1,S0}
//   wb_boot         out  SB_WARMBOOT BOOT
//   host_seen       out  sticky: USB host activity seen since reset
//   dbg_state       out  current FSM state
//   dbg_timeout_cnt out  auto-boot timeout count
//   dbg_quiet_cnt   out  consecutive quiet flash-bus cycles in DRAIN
module warmboot_sequencer
  import warmboot_sequencer_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 36_000_000,
  parameter int         CNT_W          = 26,
  parameter int         QUIET_CYCLES   = 1200,
  parameter int         BOOT_HOLD      = 16,   // must be >= ARM_CYCLES
  parameter logic [1:0] DEFAULT_IMAGE  = IMG_USER
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 usb_active,
  input  logic                                 boot_req,
  input  logic [1:0]                           boot_image,
  input  logic                                 spi_cs,
  output logic                                 spi_inhibit,
  output logic [1:0]                           wb_s,
  output logic                                 wb_boot,
  output logic                                 host_seen,
  output state_e                               dbg_state,
  output logic [CNT_W-1:0]                     dbg_timeout_cnt,
  output logic [cnt_width(QUIET_CYCLES)-1:0]   dbg_quiet_cnt
);

  localparam int QW = cnt_width(QUIET_CYCLES);
  localparam int HW = cnt_width(BOOT_HOLD);
  localparam logic [HW-1:0] ARM_LAST = HW'(ARM_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] img_q, img_d;
  logic       spi_inhibit_q, spi_inhibit_d;
  logic [1:0] wb_s_q, wb_s_d;
  logic       wb_boot_q, wb_boot_d;
  logic       host_seen_q, host_seen_d;

  logic          timeout_tc;
  logic          quiet_tc;
  logic [HW-1:0] hold_q;
  logic          hold_tc;

  // Timeout: runs only in WAIT, cleared the moment WAIT is left.
  warmboot_sequencer_sat_counter #(
    .W   (CNT_W),
    .MAX (CNT_W'(TIMEOUT_CYCLES - 1))
  ) u_timeout_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (state_d != ST_WAIT),
    .en_i    (state_q == ST_WAIT),
    .q_o     (dbg_timeout_cnt),
    .tc_o    (timeout_tc)
  );

  // Quiet: any low spi_cs sample in DRAIN restarts the quiet window.
  warmboot_sequencer_sat_counter #(
    .W   (QW),
    .MAX (QW'(QUIET_CYCLES - 1))
  ) u_quiet_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   ((state_q != ST_DRAIN) || !spi_cs),
    .en_i    (1'b1),
    .q_o     (dbg_quiet_cnt),
    .tc_o    (quiet_tc)
  );

  // Hold: shared by ARM (settle time) and FIRE (BOOT width); restarts on
  // every state change so each phase counts from zero.
  warmboot_sequencer_sat_counter #(
    .W   (HW),
    .MAX (HW'(BOOT_HOLD - 1))
  ) u_hold_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   ((state_d != state_q) || !((state_q == ST_ARM) || (state_q == ST_FIRE))),
    .en_i    (1'b1),
    .q_o     (hold_q),
    .tc_o    (hold_tc)
  );

  // Next state and image latch. boot_req outranks usb_active, which outranks
  // the timeout; the image is frozen once DRAIN is entered.
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    case (state_q)
      ST_WAIT: begin
        if (boot_req) begin
          state_d = ST_DRAIN;
          img_d   = boot_image;
        end else if (usb_active) begin
          state_d = ST_HOST;
        end else if (timeout_tc) begin
          state_d = ST_DRAIN;
          img_d   = DEFAULT_IMAGE;
        end
      end
      ST_HOST: begin
        if (boot_req) begin
          state_d = ST_DRAIN;
          img_d   = boot_image;
        end
      end
      ST_DRAIN: begin
        if (spi_cs && quiet_tc) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (hold_q == ARM_LAST) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        if (hold_tc) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // Registered outputs derived from the next state, so each output changes
  // on the same edge as the state it belongs to.
  always_comb begin
    spi_inhibit_d = (state_d == ST_DRAIN) || (state_d == ST_ARM) ||
                    (state_d == ST_FIRE)  || (state_d == ST_DONE);
    wb_boot_d     = (state_d == ST_FIRE);
    host_seen_d   = host_seen_q || (state_d == ST_HOST);
    wb_s_d        = wb_s_q;
    // S lines move only on ARM entry, well before BOOT rises.
    if ((state_d == ST_ARM) && (state_q != ST_ARM)) begin
      wb_s_d = img_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT;
      img_q         <= DEFAULT_IMAGE;
      spi_inhibit_q <= 1'b0;
      wb_s_q        <= DEFAULT_IMAGE;
      wb_boot_q     <= 1'b0;
      host_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      img_q         <= img_d;
      spi_inhibit_q <= spi_inhibit_d;
      wb_s_q        <= wb_s_d;
      wb_boot_q     <= wb_boot_d;
      host_seen_q   <= host_seen_d;
    end
  end

  assign spi_inhibit = spi_inhibit_q;
  assign wb_s        = wb_s_q;
  assign wb_boot     = wb_boot_q;
  assign host_seen   = host_seen_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_warmboot_sequencer.sv
module tb_warmboot_sequencer;
  import warmboot_sequencer_pkg::*;

  localparam int         TO  = 100;
  localparam int         CW  = 7;
  localparam int         QC  = 4;
  localparam int         BH  = 3;
  localparam logic [1:0] DEF = 2'b01;

  // ---------------- clock / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic usb_active = 1'b0;
  logic boot_req = 1'b0;
  logic [1:0] boot_image = 2'b00;
  logic spi_cs = 1'b1;
  logic spi_inhibit;
  logic [1:0] wb_s;
  logic wb_boot;
  logic host_seen;
  state_e dbg_state;
  logic [CW-1:0] dbg_timeout_cnt;
  logic [cnt_width(QC)-1:0] dbg_quiet_cnt;

  always #5 clk = ~clk;

  warmboot_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW),
    .QUIET_CYCLES   (QC),
    .BOOT_HOLD      (BH),
    .DEFAULT_IMAGE  (DEF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .usb_active      (usb_active),
    .boot_req        (boot_req),
    .boot_image      (boot_image),
    .spi_cs          (spi_cs),
    .spi_inhibit     (spi_inhibit),
    .wb_s            (wb_s),
    .wb_boot         (wb_boot),
    .host_seen       (host_seen),
    .dbg_state       (dbg_state),
    .dbg_timeout_cnt (dbg_timeout_cnt),
    .dbg_quiet_cnt   (dbg_quiet_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];   // {spi_inhibit, wb_s[1:0], wb_boot, host_seen}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Event/timeline view: once a boot decision is made, spi_inhibit is up;
  // the arm point is the edge completing QC consecutive high spi_cs samples;
  // BOOT is high for BH edges starting 2 edges after the arm point.
  int         m_edge, m_idle, m_run, m_arm_at;
  logic       m_decided, m_host;
  logic [1:0] m_img;

  function automatic void model_step(input logic r, input logic u, input logic b,
                                     input logic [1:0] img, input logic cs);
    logic boot_e;
    if (r) begin
      m_edge = 0; m_idle = 0; m_run = 0; m_arm_at = -1;
      m_decided = 1'b0; m_host = 1'b0; m_img = DEF;
    end else begin
      m_edge++;
      if (!m_decided) begin
        if (b) begin
          m_decided = 1'b1; m_img = img;
        end else if (!m_host) begin
          if (u) m_host = 1'b1;
          else begin
            m_idle++;
            if (m_idle == TO) begin m_decided = 1'b1; m_img = DEF; end
          end
        end
      end else if (m_arm_at < 0) begin
        m_run = cs ? m_run + 1 : 0;
        if (m_run == QC) m_arm_at = m_edge;
      end
    end
    boot_e = (m_arm_at >= 0) && (m_edge >= m_arm_at + 2) && (m_edge < m_arm_at + 2 + BH);
    exp_q.push_back({m_decided, (m_arm_at >= 0) ? m_img : DEF, boot_e, m_host});
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input string tag, input logic r, input logic u, input logic b,
                       input logic [1:0] img, input logic cs);
    logic [4:0] e;
    reset = r; usb_active = u; boot_req = b; boot_image = img; spi_cs = cs;
    @(posedge clk);
    #1;
    model_step(r, u, b, img, cs);
    e = exp_q.pop_front();
    check({tag, "_model"}, {27'd0, spi_inhibit, wb_s, wb_boot, host_seen}, {27'd0, e});
  endtask

  // Idle bus, no USB: decision at edge TO, ARM QC edges later, BOOT 2 after ARM.
  task automatic measure_idle_boot(input string tag);
    int first_inh = -1;
    int first_boot = -1;
    int boot_cnt = 0;
    for (int k = 1; k <= 120; k++) begin
      cycle(tag, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      if (spi_inhibit && first_inh < 0) first_inh = k;
      if (wb_boot) begin
        boot_cnt++;
        if (first_boot < 0) first_boot = k;
      end
    end
    check({tag, "_inhibit_edge"}, first_inh, 100);
    check({tag, "_boot_edge"}, first_boot, 106);
    check({tag, "_boot_width"}, boot_cnt, 3);
    check({tag, "_host_seen"}, host_seen, 0);
    check({tag, "_done"}, dbg_state, ST_DONE);
    check({tag, "_wb_s"}, wb_s, DEF);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, usb, req;
    logic [1:0] img;
    logic cs;
    int n;
    logic inh;
    logic [1:0] s;
    logic boot, host;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Host-requested boot with a busy flash bus.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1,  2, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b1,  1, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 20, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0,  1, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1,  3, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1,  1, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1,  1, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1,  3, 1'b1, 2'b10, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1,  5, 1'b1, 2'b10, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b1,  3, 1'b1, 2'b10, 1'b0, 1'b1};

    // ---- reset state ----
    cycle("reset", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    check("reset_state", dbg_state, ST_WAIT);
    check("reset_timeout_cnt", dbg_timeout_cnt, 0);
    check("reset_quiet_cnt", dbg_quiet_cnt, 0);
    check("reset_outputs", {spi_inhibit, wb_s, wb_boot, host_seen}, {1'b0, DEF, 1'b0, 1'b0});

    // ---- 1: timeout auto-boot ----
    measure_idle_boot("t1");

    // ---- 2: USB host appears, no timeout ----
    begin
      int saw_boot = 0;
      int saw_inh = 0;
      cycle("t2", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
      for (int k = 1; k < 50; k++) cycle("t2", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      cycle("t2", 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
      for (int k = 0; k < 1000; k++) begin
        cycle("t2", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        if (wb_boot) saw_boot++;
        if (spi_inhibit) saw_inh++;
      end
      check("t2_host_seen", host_seen, 1);
      check("t2_no_boot", saw_boot, 0);
      check("t2_no_inhibit", saw_inh, 0);
      check("t2_state", dbg_state, ST_HOST);
    end

    // ---- 3: table-driven host request ----
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        cycle("t3", tbl[i].rst, tbl[i].usb, tbl[i].req, tbl[i].img, tbl[i].cs);
        check($sformatf("t3_vec%0d", i), {spi_inhibit, wb_s, wb_boot, host_seen},
              {tbl[i].inh, tbl[i].s, tbl[i].boot, tbl[i].host});
      end
    end

    // ---- 4: boot_req coincides with timeout; later request ignored ----
    cycle("t4", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    for (int k = 1; k < TO; k++) cycle("t4", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("t4_timeout_cnt", dbg_timeout_cnt, TO - 1);
    cycle("t4", 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    check("t4_inhibit", spi_inhibit, 1);
    cycle("t4", 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
    for (int k = 0; k < 12; k++) cycle("t4", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("t4_image", wb_s, 2'b11);
    check("t4_done", dbg_state, ST_DONE);

    // ---- 5: reset during FIRE, then clean restart ----
    cycle("t5", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    cycle("t5", 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    for (int k = 0; k < QC + 2; k++) cycle("t5", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("t5_in_fire", {wb_boot, wb_s}, {1'b1, 2'b10});
    cycle("t5", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    check("t5_after_reset", {spi_inhibit, wb_s, wb_boot}, {1'b0, DEF, 1'b0});
    measure_idle_boot("t5");

    // ---- 6: chatty flash bus blocks ARM; quiet bus arms after QC ----
    begin
      int left_drain = 0;
      int arm_after = -1;
      cycle("t6", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
      cycle("t6", 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
      for (int k = 0; k < 30; k++) begin
        cycle("t6", 1'b0, 1'b0, 1'b0, 2'b00, (k % 3) != 2);
        if (dbg_state != ST_DRAIN) left_drain++;
      end
      check("t6_stays_drain", left_drain, 0);
      check("t6_wb_s_held", wb_s, DEF);
      for (int k = 1; k <= 20 && arm_after < 0; k++) begin
        cycle("t6", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        if (dbg_state == ST_ARM) arm_after = k;
      end
      check("t6_arm_latency", arm_after, QC);
      check("t6_wb_s_armed", wb_s, 2'b10);
    end

    // ---- randomized run against the model ----
    cycle("rnd", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 4000; k++) begin
      cycle("rnd",
            $urandom_range(0, 499) == 0,
            $urandom_range(0, 249) == 0,
            $urandom_range(0, 179) == 0,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 4) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
